filter_feeder: RTL

- Upstream partner of the audio filter control block.
- Buffers signed ADC samples arriving on a sample strobe and issues them one at a time to the filter over a start/done handshake.
- Collects each filtered result and presents it on a registered output with a one-cycle valid pulse.
- When the filter switch is off, samples bypass the filter. Sits between the ADC capture logic and the DAC/PWM output stage.

---
 rtl/filter_feeder_pkg.sv | 21 ++
 rtl/filter_feeder_sample_fifo.sv | 80 ++++++++
 rtl/filter_feeder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/filter_feeder_pkg.sv
// Shared definitions for the audio filter feeder: sequencer state encoding and
// the default sample width used by the feeder and its input buffer.
// Latency: n/a (types and constants only). Backpressure: n/a.
package filter_feeder_pkg;

    // Default ADC/DAC sample width (signed two's complement).
    localparam int AUDIO_WIDTH = 12;

    // Filter handshake sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // waiting for a buffered sample
        ST_START = 2'd1,  // one-cycle start pulse to the filter
        ST_WAIT  = 2'd2   // waiting for filt_done or timeout
    } feed_state_t;

    // Width of a counter that must be able to hold max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/filter_feeder_sample_fifo.sv
// Synchronous sample buffer with full/empty/level.
// Latency: a pushed sample is visible at head_o the cycle after the push.
// Backpressure: a push when full is ignored unless a pop happens in the same cycle.
// Ports: clock/reset_n; push_i + push_dat_i write side; pop_i read side with
// head_o showing the oldest entry; full_o, empty_o, level_o (0..DEPTH) status.
module sample_fifo
    import filter_feeder_pkg::*;
#(
    parameter int WIDTH = AUDIO_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // When full, the slot being written is the one being read this cycle; the
    // head is read combinationally before the edge, so the overwrite is safe.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/filter_feeder.sv
// Buffers ADC samples and feeds them to an external filter over start/done, or
// bypasses the filter; results leave on a registered output with a valid pulse.
// Latency: bypass strobe N -> audio_valid N+2; filtered strobe N -> filt_start N+2,
// done D -> audio_valid D+1. Backpressure: none upstream; samples arriving with a
// full buffer are dropped and flagged in the sticky overflow bit.
// Ports: sample_strobe/sample_in (ADC side), filter_enable, clear_flags,
// filt_start/filt_sample/filt_done/filt_result (filter handshake),
// audio_out/audio_valid (DAC side), fifo_level, overflow, timeout_err.
module filter_feeder
    import filter_feeder_pkg::*;
#(
    parameter int WIDTH      = AUDIO_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          sample_strobe,
    input  logic [WIDTH-1:0]              sample_in,
    input  logic                          filter_enable,
    input  logic                          clear_flags,
    output logic                          filt_start,
    output logic [WIDTH-1:0]              filt_sample,
    input  logic                          filt_done,
    input  logic [WIDTH-1:0]              filt_result,
    output logic [WIDTH-1:0]              audio_out,
    output logic                          audio_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          timeout_err
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

    feed_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] filt_sample_q, filt_sample_d;
    logic [WIDTH-1:0] audio_q, audio_d;
    logic             audio_vld_q, audio_vld_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;

    logic             pop;
    logic             push;
    logic             ovf_set;
    logic             tmo_set;
    logic [WIDTH-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;

    // Accept while not full, or when full but the head leaves this same cycle.
    assign push    = sample_strobe && (!fifo_full || pop);
    assign ovf_set = sample_strobe && !push;

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (push),
        .push_dat_i (sample_in),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        filt_sample_d = filt_sample_q;
        audio_d       = audio_q;
        audio_vld_d   = 1'b0;
        pop           = 1'b0;
        tmo_set       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    // The route is decided here, once per sample.
                    if (filter_enable) begin
                        filt_sample_d = head;
                        state_d       = ST_START;
                    end else begin
                        audio_d     = head;
                        audio_vld_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done is tested first so it wins over a coincident timeout.
                if (filt_done) begin
                    audio_d     = filt_result;
                    audio_vld_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (cnt_q == TMO_CNT) begin
                    audio_d     = filt_sample_q;
                    audio_vld_d = 1'b1;
                    tmo_set     = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A set in the same cycle as a clear must survive.
        ovf_d = ovf_set ? 1'b1 : (clear_flags ? 1'b0 : ovf_q);
        tmo_d = tmo_set ? 1'b1 : (clear_flags ? 1'b0 : tmo_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            filt_sample_q <= '0;
            audio_q       <= '0;
            audio_vld_q   <= 1'b0;
            ovf_q         <= 1'b0;
            tmo_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            filt_sample_q <= filt_sample_d;
            audio_q       <= audio_d;
            audio_vld_q   <= audio_vld_d;
            ovf_q         <= ovf_d;
            tmo_q         <= tmo_d;
        end
    end

    assign filt_start  = (state_q == ST_START);
    assign filt_sample = filt_sample_q;
    assign audio_out   = audio_q;
    assign audio_valid = audio_vld_q;
    assign overflow    = ovf_q;
    assign timeout_err = tmo_q;

endmodule
